// File: rtl/otter_fetch_pkg.sv
// Shared types and defaults for the OTTER instruction-fetch front end.
package otter_fetch_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam logic [XLEN_DEFAULT-1:0] RESET_VEC_DEFAULT = 32'h0000_0000;

  // One queued fetch result: the PC it was read from and the instruction word.
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] ir;
  } fetch_entry_t;

endpackage : otter_fetch_pkg

// File: rtl/otter_sync_fifo.sv
// Synchronous circular FIFO with a separately tracked occupancy count and a
// single-cycle clear that overrides push/pop.
module otter_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer and occupancy next-state; clear wins over any push or pop.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the count marks which slots are meaningful and callers gate the head on it.
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule : otter_sync_fifo

// File: rtl/otter_fetch_queue.sv
// Instruction-fetch front end: PC generator, one-outstanding synchronous IMEM
// requester and a prefetch FIFO delivering {PC, IR} pairs to Decode.
module otter_fetch_queue
  import otter_fetch_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEFAULT,
  parameter int unsigned     DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_VEC = RESET_VEC_DEFAULT,
  parameter int unsigned     PC_STEP   = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     REDIRECT,
  input  logic [XLEN-1:0]          REDIRECT_PC,
  output logic                     IMEM_RD,
  output logic [XLEN-1:0]          IMEM_ADDR,
  input  logic [XLEN-1:0]          IMEM_DOUT,
  output logic                     DEC_VALID,
  output logic [XLEN-1:0]          DEC_IR,
  output logic [XLEN-1:0]          DEC_PC,
  input  logic                     DEC_READY,
  output logic [$clog2(DEPTH):0]   Q_COUNT
);

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);
  localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);

  logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]    req_pc_q, req_pc_d;
  logic               inflight_q, inflight_d;

  logic [CNT_W-1:0]   count;
  logic               fifo_empty, fifo_full;
  logic               pop, fifo_pop, push, issue;
  logic [CNT_W:0]     credit;
  fetch_entry_t       push_entry, head_entry;
  logic [ENTRY_W-1:0] head_raw;

  // A pop during a redirect is discarded: the clear empties the queue anyway.
  assign pop      = DEC_VALID & DEC_READY;
  assign fifo_pop = pop & ~REDIRECT;
  // A response landing in a redirect cycle belongs to the old stream.
  assign push     = inflight_q & ~REDIRECT;

  // Slots already promised (queued + in flight) minus the one leaving this
  // cycle; issuing only below DEPTH means a response always finds room.
  assign credit = {1'b0, count} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
  // RST_N gates the strobe so no read is requested while held in reset.
  assign issue  = RST_N & ~REDIRECT & (credit < DEPTH_W);

  // PC generator and in-flight tracking next-state.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    if (REDIRECT) begin
      fetch_pc_d = REDIRECT_PC;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
      req_pc_d   = fetch_pc_q;
    end
  end

  // Fetch state registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fetch_pc_q <= RESET_VEC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  assign push_entry = '{pc: req_pc_q, ir: IMEM_DOUT};

  otter_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .clear_i (REDIRECT),
    .data_o  (head_raw),
    .count_o (count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign head_entry = fetch_entry_t'(head_raw);

  assign IMEM_RD   = issue;
  assign IMEM_ADDR = fetch_pc_q;
  assign DEC_VALID = ~fifo_empty;
  // Head fields are forced to zero when empty so unwritten storage never leaks out.
  assign DEC_PC    = DEC_VALID ? head_entry.pc : '0;
  assign DEC_IR    = DEC_VALID ? head_entry.ir : '0;
  assign Q_COUNT   = count;

  // The credit check must make push-into-full unreachable.
  a_no_overflow : assert property (@(posedge CLK) disable iff (!RST_N)
    !(push && fifo_full && !fifo_pop));

endmodule : otter_fetch_queue

// File: tb/tb_otter_fetch_queue.sv
// Self-checking bench for otter_fetch_queue: table-driven stream/stall vectors
// followed by hand-written redirect and reset sequences.
module tb_otter_fetch_queue;

  localparam logic [31:0] KEY = 32'h1357_9BDF;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        IMEM_RD;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_DOUT;
  logic        DEC_VALID;
  logic [31:0] DEC_IR;
  logic [31:0] DEC_PC;
  logic        DEC_READY;
  logic [2:0]  Q_COUNT;

  int total = 0;
  int bad   = 0;

  otter_fetch_queue dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .IMEM_RD     (IMEM_RD),
    .IMEM_ADDR   (IMEM_ADDR),
    .IMEM_DOUT   (IMEM_DOUT),
    .DEC_VALID   (DEC_VALID),
    .DEC_IR      (DEC_IR),
    .DEC_PC      (DEC_PC),
    .DEC_READY   (DEC_READY),
    .Q_COUNT     (Q_COUNT)
  );

  always #5 CLK = ~CLK;

  // Synchronous IMEM: data is a keyed copy of the address, one cycle after the strobe.
  initial IMEM_DOUT = 32'hDEAD_BEEF;
  always @(posedge CLK) if (IMEM_RD) IMEM_DOUT <= IMEM_ADDR ^ KEY;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        ready;
    logic        rd;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ir_of(input logic [31:0] pc);
    return pc ^ KEY;
  endfunction

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Leaves the bench 1 time unit into cycle 0 with reset just released.
  task automatic do_reset(input logic rdy);
    RST_N       = 1'b0;
    REDIRECT    = 1'b0;
    REDIRECT_PC = '0;
    DEC_READY   = rdy;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic check_head(input string name, input logic [31:0] pc);
    check({name, "_valid"}, {31'b0, DEC_VALID}, 32'd1);
    check({name, "_pc"}, DEC_PC, pc);
    check({name, "_ir"}, DEC_IR, ir_of(pc));
  endtask

  // Waits (bounded) for the first valid head and returns its PC and cycle offset.
  task automatic wait_valid(input string name, input int limit, output logic [31:0] pc, output int k);
    pc = 32'hFFFF_FFFF;
    k  = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge CLK);
      if (DEC_VALID) begin
        pc = DEC_PC;
        k  = i;
        break;
      end
      next_cycle();
    end
    if (k < 0) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] addrs[$];
    logic [31:0] pc;
    int          k;

    // Stream with DEC_READY high, then a stall to full, then resume.
    vecs.push_back('{1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 3'd0});
    vecs.push_back('{1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 3'd0});
    vecs.push_back('{1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 3'd1});
    vecs.push_back('{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04, 3'd1});
    vecs.push_back('{1'b1, 1'b1, 32'h10, 1'b1, 32'h08, 3'd1});
    vecs.push_back('{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C, 3'd1});
    vecs.push_back('{1'b0, 1'b1, 32'h18, 1'b1, 32'h10, 3'd1});
    vecs.push_back('{1'b0, 1'b1, 32'h1C, 1'b1, 32'h10, 3'd2});
    vecs.push_back('{1'b0, 1'b0, 32'h20, 1'b1, 32'h10, 3'd3});
    vecs.push_back('{1'b0, 1'b0, 32'h20, 1'b1, 32'h10, 3'd4});
    vecs.push_back('{1'b1, 1'b1, 32'h20, 1'b1, 32'h10, 3'd4});
    vecs.push_back('{1'b1, 1'b1, 32'h24, 1'b1, 32'h14, 3'd3});
    vecs.push_back('{1'b1, 1'b1, 32'h28, 1'b1, 32'h18, 3'd3});
    vecs.push_back('{1'b1, 1'b1, 32'h2C, 1'b1, 32'h1C, 3'd3});
    vecs.push_back('{1'b1, 1'b1, 32'h30, 1'b1, 32'h20, 3'd3});

    // Reset state, sampled while reset is held.
    RST_N = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = '0; DEC_READY = 1'b1;
    #3;
    check("rst_imem_rd", {31'b0, IMEM_RD}, 32'd0);
    check("rst_valid",   {31'b0, DEC_VALID}, 32'd0);
    check("rst_count",   {29'b0, Q_COUNT}, 32'd0);
    check("rst_pc",      DEC_PC, 32'd0);
    check("rst_ir",      DEC_IR, 32'd0);

    do_reset(1'b1);
    for (int i = 0; i < vecs.size(); i++) begin
      DEC_READY = vecs[i].ready;
      @(negedge CLK);
      check($sformatf("v%0d_rd", i),    {31'b0, IMEM_RD}, {31'b0, vecs[i].rd});
      check($sformatf("v%0d_addr", i),  IMEM_ADDR, vecs[i].addr);
      check($sformatf("v%0d_valid", i), {31'b0, DEC_VALID}, {31'b0, vecs[i].valid});
      check($sformatf("v%0d_pc", i),    DEC_PC, vecs[i].valid ? vecs[i].pc : 32'd0);
      check($sformatf("v%0d_ir", i),    DEC_IR, vecs[i].valid ? ir_of(vecs[i].pc) : 32'd0);
      check($sformatf("v%0d_cnt", i),   {29'b0, Q_COUNT}, {29'b0, vecs[i].cnt});
      next_cycle();
    end

    // Stall from reset: exactly DEPTH reads, then a gap-free drain.
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (IMEM_RD) addrs.push_back(IMEM_ADDR);
      if (i == 7) check("stall_count", {29'b0, Q_COUNT}, 32'd4);
      next_cycle();
    end
    check("stall_reads", addrs.size(), 32'd4);
    for (int i = 0; i < addrs.size(); i++)
      check($sformatf("stall_addr%0d", i), addrs[i], 32'(4 * i));
    DEC_READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check_head($sformatf("drain%0d", i), 32'(4 * i));
      next_cycle();
    end

    // Redirect with 3 queued and one read in flight.
    do_reset(1'b0);
    repeat (4) next_cycle();
    REDIRECT = 1'b1; REDIRECT_PC = 32'h100;
    @(negedge CLK);
    check("redir_pre_count", {29'b0, Q_COUNT}, 32'd3);
    check("redir_imem_rd",   {31'b0, IMEM_RD}, 32'd0);
    next_cycle();
    REDIRECT = 1'b0;
    @(negedge CLK);
    check("redir_t1_count", {29'b0, Q_COUNT}, 32'd0);
    check("redir_t1_valid", {31'b0, DEC_VALID}, 32'd0);
    check("redir_t1_rd",    {31'b0, IMEM_RD}, 32'd1);
    check("redir_t1_addr",  IMEM_ADDR, 32'h100);
    next_cycle();
    @(negedge CLK);
    check("redir_t2_count", {29'b0, Q_COUNT}, 32'd0);
    check("redir_t2_valid", {31'b0, DEC_VALID}, 32'd0);
    next_cycle();
    @(negedge CLK);
    check_head("redir_t3", 32'h100);
    next_cycle();

    // Back-to-back redirects: the second target wins.
    DEC_READY = 1'b1;
    REDIRECT = 1'b1; REDIRECT_PC = 32'h200;
    next_cycle();
    REDIRECT_PC = 32'h300;
    @(negedge CLK);
    check("dbl_imem_rd", {31'b0, IMEM_RD}, 32'd0);
    next_cycle();
    REDIRECT = 1'b0;
    wait_valid("dbl", 10, pc, k);
    check("dbl_first_pc", pc, 32'h300);
    check("dbl_latency", k, 32'd2);
    check("dbl_first_ir", DEC_IR, ir_of(32'h300));
    next_cycle();
    next_cycle();

    // Redirect coinciding with a pop.
    REDIRECT = 1'b1; REDIRECT_PC = 32'h400;
    @(negedge CLK);
    check("rpop_pre_valid", {31'b0, DEC_VALID}, 32'd1);
    next_cycle();
    REDIRECT = 1'b0;
    @(negedge CLK);
    check("rpop_count", {29'b0, Q_COUNT}, 32'd0);
    check("rpop_valid", {31'b0, DEC_VALID}, 32'd0);
    next_cycle();
    wait_valid("rpop", 10, pc, k);
    check("rpop_first_pc", pc, 32'h400);
    check("rpop_latency", k, 32'd1);
    next_cycle();

    // Fill the queue, then pulse reset for one cycle.
    DEC_READY = 1'b0;
    repeat (6) next_cycle();
    @(negedge CLK);
    check("rst2_pre_count", {29'b0, Q_COUNT}, 32'd4);
    next_cycle();
    RST_N = 1'b0;
    #1;
    check("rst2_imem_rd", {31'b0, IMEM_RD}, 32'd0);
    check("rst2_valid",   {31'b0, DEC_VALID}, 32'd0);
    check("rst2_count",   {29'b0, Q_COUNT}, 32'd0);
    check("rst2_pc",      DEC_PC, 32'd0);
    check("rst2_ir",      DEC_IR, 32'd0);
    next_cycle();
    RST_N = 1'b1;
    DEC_READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (i < 2) check($sformatf("rst2_c%0d_valid", i), {31'b0, DEC_VALID}, 32'd0);
      else check_head($sformatf("rst2_c%0d", i), 32'(4 * (i - 2)));
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_otter_fetch_queue

// File: doc/otter_fetch_queue.md
Name: otter_fetch_queue

Overview:
- Parametrised instruction-fetch front end for the pipelined OTTER.
- Replaces the bare PC register plus the enable-gated IR/PC decode latches with a PC generator, a one-outstanding sync-read IMEM requester and a DEPTH-entry prefetch FIFO.
- Delivers {PC, IR} pairs to Decode under a valid/ready handshake.
- Handles branch/jump redirects by flushing queued and in-flight fetches (no external delay/persist logic needed).

Parameters:
- XLEN, 32: address/instruction width.
- DEPTH, 4: prefetch FIFO entries; power of two, >= 2.
- RESET_VEC, 32'h0000_0000: first fetch address after reset.
- PC_STEP, 4: sequential PC increment.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REDIRECT  in  1  redirect request from Decode/Execute (branch taken, jal, jalr, trap, mret).
- REDIRECT_PC  in  XLEN  new fetch address, sampled when REDIRECT=1.
- IMEM_RD  out  1  instruction read strobe.
- IMEM_ADDR  out  XLEN  instruction read address, valid when IMEM_RD=1.
- IMEM_DOUT  in  XLEN  read data, valid exactly 1 cycle after IMEM_RD.
- DEC_VALID  out  1  head entry valid.
- DEC_IR  out  XLEN  head instruction.
- DEC_PC  out  XLEN  head PC.
- DEC_READY  in  1  Decode accepts head this cycle; pop = DEC_VALID & DEC_READY.
- Q_COUNT  out  $clog2(DEPTH)+1  current FIFO occupancy (debug/perf).

Behaviour:
- Reset (async, RST_N=0):
  - fetch_pc=RESET_VEC, inflight=0, FIFO empty.
  - IMEM_RD=0, DEC_VALID=0, Q_COUNT=0, DEC_IR/DEC_PC=0.
- Issue rule, evaluated each cycle:
  - issue = !REDIRECT & (count + inflight - pop < DEPTH).
  - IMEM_RD=issue, IMEM_ADDR=fetch_pc.
  - On issue: fetch_pc += PC_STEP, req_pc <= fetch_pc, inflight <= 1; otherwise inflight <= 0.
- Response: in the cycle after an issue (inflight=1) with no REDIRECT, push {req_pc, IMEM_DOUT} at the cycle's end. The entry is visible on DEC_* the following cycle.
- Latency: reset release at cycle 0 → IMEM_RD at cycle 0 → push at end of cycle 1 → DEC_VALID at cycle 2.
- Steady-state throughput: 1 instruction/cycle when DEC_READY is held high.
- Overflow: the pop-aware credit check guarantees a push never hits a full FIFO. Push-while-full is an assertion failure.
- Stall (DEC_READY=0):
  - Head and DEC_* held stable.
  - Issue stops once count+inflight=DEPTH.
  - An in-flight response is still captured.
- Redirect (REDIRECT=1 in cycle t):
  - FIFO cleared at end of t; any pop that cycle is discarded.
  - Any response arriving in t is dropped; inflight <= 0.
  - fetch_pc <= REDIRECT_PC; IMEM_RD=0 in t.
  - First new read issues in t+1; DEC_VALID for REDIRECT_PC in t+3.
  - Redirect in consecutive cycles: the last one wins.
- FIFO: circular rd/wr pointers of $clog2(DEPTH) bits wrap naturally; count is tracked separately.
  - Simultaneous push+pop keeps count unchanged.
  - Pop when empty is impossible, since pop requires DEC_VALID.
- PC arithmetic is modulo 2^XLEN; wrap from 32'hFFFF_FFFC to 0 is legal and silent.
- Reset mid-operation: immediate return to the reset state.
  - The memory response of a read issued before reset is ignored because inflight=0.

Decomposition:
- Package otter_fetch_pkg:
  - XLEN default constant.
  - typedef struct packed {logic [XLEN-1:0] pc; logic [XLEN-1:0] ir;} fetch_entry_t.
  - RESET_VEC default.
- Sub-module otter_sync_fifo:
  - parametrised width/DEPTH; push/pop/clear; count/empty/full; async active-low reset.
  - Instantiated once with fetch_entry_t width.
- PC/issue/inflight logic lives in the top.

Test Plan:
- Reset release, IMEM model returns {addr} as data, DEC_READY=1 → DEC_VALID at cycle 2 with DEC_PC=0, then PCs 4, 8, 12 on consecutive cycles, one per cycle.
- DEC_READY=0 from reset, DEPTH=4 → IMEM_RD pulses exactly 4 times (addrs 0, 4, 8, C). Q_COUNT settles at 4. Raise DEC_READY → PCs 0, 4, 8, C, 10 delivered in order with no gaps.
- REDIRECT=1, REDIRECT_PC=32'h100 while 3 entries are queued and a read is in flight → next cycle Q_COUNT=0, DEC_VALID=0. Stale response not enqueued. DEC_PC=0x100 appears exactly 3 cycles after the redirect cycle.
- REDIRECT asserted two consecutive cycles (0x200, then 0x300) → no fetch of 0x200 is delivered. First DEC_PC=0x300.
- Simultaneous REDIRECT and pop (DEC_VALID=DEC_READY=1) → popped entry not counted as consumed again. Queue empty next cycle; first delivered PC = REDIRECT_PC.
- RST_N pulsed low for 1 cycle mid-stream with queue full → all outputs 0 during reset. Restart fetch at RESET_VEC. No stale IR is ever delivered.
